// File: rtl/bp_pkg.sv
// Shared constants, FSM encoding and helpers for the blood-pressure averager.
package bp_pkg;

  localparam int BP_W          = 9;
  localparam int CNT_W         = 8;
  localparam int MAX_BP_DEF    = 300;
  localparam int SPIKE_THR_DEF = 40;

  // FILL: window still filling, no output updates. RUN: window full.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bp_averager_if.sv
// Sample-in / BP-out bundle between the raw sample source and the averager.
//
// Handshake: sample_valid qualifies sample for exactly one clk cycle. There is
// no ready; every valid beat is taken unless flush is high in the same cycle.
// On the output side bp_valid is a one-cycle pulse qualifying a new bp_out;
// bp_out is held stable between pulses. bp_stable is a level, not a pulse.
interface bp_averager_if;

  logic                     sample_valid;
  logic [bp_pkg::BP_W-1:0]  sample;
  logic                     flush;
  logic [bp_pkg::BP_W-1:0]  bp_out;
  logic                     bp_valid;
  logic                     bp_stable;
  logic [bp_pkg::CNT_W-1:0] clamp_cnt;
  logic [bp_pkg::CNT_W-1:0] spike_cnt;

  // Sample source / BP consumer side.
  modport master (
    output sample_valid, sample, flush,
    input  bp_out, bp_valid, bp_stable, clamp_cnt, spike_cnt
  );

  // Averager side.
  modport slave (
    input  sample_valid, sample, flush,
    output bp_out, bp_valid, bp_stable, clamp_cnt, spike_cnt
  );

endinterface

// File: rtl/bp_ring_buf.sv
// N x BP_W circular sample store with wrapping write pointer. The entry at
// the write pointer is the oldest sample, i.e. the one the next write evicts.
module bp_ring_buf
  import bp_pkg::*;
#(
  parameter int LOG2N = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [BP_W-1:0] wr_data,
  output logic [BP_W-1:0] oldest
);

  localparam int N = 1 << LOG2N;

  logic [BP_W-1:0]  mem_q [N];
  logic [BP_W-1:0]  mem_d [N];
  logic [LOG2N-1:0] wp_q, wp_d;

  // Next storage contents and pointer; N is a power of two so wrap is free.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    if (clear) begin
      wp_d = '0;
    end else if (wr_en) begin
      mem_d[wp_q] = wr_data;
      wp_d        = wp_q + 1'b1;
    end
  end

  // Write pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wp_q <= '0;
    else        wp_q <= wp_d;
  end

  // Storage has no reset; contents are only read once the window refills.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign oldest = mem_q[wp_q];

endmodule

// File: rtl/bp_averager.sv
// Clamping sliding-window BP averager feeding the ADH stage.
// Optional outlier rejection in RUN is enabled by defining BP_SPIKE_REJECT_EN.
module bp_averager
  import bp_pkg::*;
#(
  parameter int LOG2N     = 3,
  parameter int MAX_BP    = MAX_BP_DEF,
  parameter int SPIKE_THR = SPIKE_THR_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  bp_averager_if.slave  bus,
  output bp_state_e     dbg_state
);

  localparam int               SUM_W = BP_W + LOG2N;
  localparam logic [BP_W-1:0]  MAX_V = BP_W'(MAX_BP);
  localparam logic [LOG2N-1:0] LAST  = LOG2N'((1 << LOG2N) - 1);

  bp_state_e         state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [LOG2N-1:0]  cnt_q, cnt_d;
  logic              stable_q, stable_d;
  logic              pend_q, pend_d;
  logic [BP_W-1:0]   out_q, out_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  clamp_q, clamp_d;

  logic              accept, is_clamp, reject, take;
  logic [BP_W-1:0]   s;
  logic [BP_W-1:0]   oldest;

  assign accept   = bus.sample_valid & ~bus.flush;
  assign is_clamp = bus.sample > MAX_V;
  assign s        = is_clamp ? MAX_V : bus.sample;
  assign take     = accept & ~reject;

`ifdef BP_SPIKE_REJECT_EN
  logic [BP_W-1:0]  diff;
  logic [CNT_W-1:0] spike_q, spike_d;

  // Outlier test against the currently published mean, RUN only.
  always_comb begin
    diff    = (s > out_q) ? (s - out_q) : (out_q - s);
    reject  = accept & (state_q == ST_RUN) & (diff > BP_W'(SPIKE_THR));
    spike_d = reject ? sat_inc(spike_q) : spike_q;
  end

  // Rejected-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_q <= '0;
    else        spike_q <= spike_d;
  end

  assign bus.spike_cnt = spike_q;
`else
  assign reject        = 1'b0;
  assign bus.spike_cnt = '0;
`endif

  bp_ring_buf #(.LOG2N(LOG2N)) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.flush),
    .wr_en   (take),
    .wr_data (s),
    .oldest  (oldest)
  );

  // FSM next state, accumulator, stage-2 output update and clamp counter.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    pend_d   = 1'b0;
    out_d    = out_q;
    valid_d  = 1'b0;
    clamp_d  = (accept && is_clamp) ? sat_inc(clamp_q) : clamp_q;
    if (bus.flush) begin
      // Restart window; a pending output update is dropped, bp_out held.
      state_d  = ST_FILL;
      sum_d    = '0;
      cnt_d    = '0;
      stable_d = 1'b0;
    end else begin
      if (pend_q) begin
        out_d   = sum_q[SUM_W-1:LOG2N];
        valid_d = 1'b1;
      end
      if (take) begin
        unique case (state_q)
          ST_FILL: begin
            sum_d = sum_q + SUM_W'(s);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_d  = ST_RUN;
              stable_d = 1'b1;
              pend_d   = 1'b1;
            end
          end
          ST_RUN: begin
            sum_d  = sum_q - SUM_W'(oldest) + SUM_W'(s);
            pend_d = 1'b1;
          end
          default: state_d = ST_FILL;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      sum_q    <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pend_q   <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      clamp_q  <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      clamp_q  <= clamp_d;
    end
  end

  assign bus.bp_out    = out_q;
  assign bus.bp_valid  = valid_q;
  assign bus.bp_stable = stable_q;
  assign bus.clamp_cnt = clamp_q;
  assign dbg_state     = state_q;

endmodule
